alu_sequencer: RTL and testbench

- Multi-cycle control unit for the 10-bit datapath; it is the issuing end of the ALU's FN/operand interface.
- Accepts one instruction per EXEC handshake and decodes opcode and register fields.
- Sequences the register file, A latch, G result register and bus muxes, driving FN to the ALU in the execute step.
- Handles LOAD and COPY by bus routing only, because the ALU returns 0 for those codes.

---
 rtl/alu_sequencer_if.sv | 31 +++
 rtl/alu_sequencer.sv | 149 ++++++++++++++
 tb/tb_alu_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Instruction handshake plus datapath control bundle between a host,
// the ALU sequencer and the 10-bit datapath (register file, A latch, G, bus muxes).
interface alu_sequencer_if #(
    parameter int IW   = 10,
    parameter int NREG = 4
);
    logic            EXEC;
    logic [IW-1:0]   INSTR;
    logic            BUSY;
    logic            DONE;
    logic            ERR;
    logic [3:0]      FN;
    logic [NREG-1:0] RIN;
    logic [NREG-1:0] ROUT;
    logic            EXTERN;
    logic            AIN;
    logic            GIN;
    logic            GOUT;

    // Sequencer side: consumes instructions, issues FN and datapath enables.
    modport master (
        input  EXEC, INSTR,
        output BUSY, DONE, ERR, FN, RIN, ROUT, EXTERN, AIN, GIN, GOUT
    );

    // Host / datapath side.
    modport slave (
        output EXEC, INSTR,
        input  BUSY, DONE, ERR, FN, RIN, ROUT, EXTERN, AIN, GIN, GOUT
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle control unit: latches one instruction per EXEC handshake and
// steps register file, A latch, G register and bus muxes through IDLE/T1/T2/T3.
module alu_sequencer #(
    parameter int IW   = 10,
    parameter int NREG = 4
) (
    input  logic            CLK,
    input  logic            RSTN,
    alu_sequencer_if.master bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] T1   = 2'd1;
    localparam logic [1:0] T2   = 2'd2;
    localparam logic [1:0] T3   = 2'd3;

    localparam logic [3:0] OP_LOAD     = 4'h0;
    localparam logic [3:0] OP_COPY     = 4'h1;
    localparam logic [3:0] OP_LAST_ALU = 4'hB;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [IW-1:0] ir;

    logic [3:0] opcode;
    logic [1:0] rx;
    logic [1:0] ry;
    logic       is_load;
    logic       is_copy;
    logic       is_alu;
    logic       is_illegal;

    logic            busy;
    logic            done;
    logic            err;
    logic [3:0]      fn;
    logic [NREG-1:0] rin;
    logic [NREG-1:0] rout;
    logic            extern_en;
    logic            ain;
    logic            gin;
    logic            gout;

    // Reserved instruction bits are carried in IR but never decoded.
    logic unused_rsvd;
    assign unused_rsvd = ^ir[1:0];

    function automatic logic [NREG-1:0] reg_sel(input logic [1:0] idx);
        logic [NREG-1:0] sel;
        sel = '0;
        for (int i = 0; i < NREG; i++) begin
            if (int'(idx) == i) sel[i] = 1'b1;
        end
        return sel;
    endfunction

    assign opcode     = ir[9:6];
    assign rx         = ir[5:4];
    assign ry         = ir[3:2];
    assign is_load    = (opcode == OP_LOAD);
    assign is_copy    = (opcode == OP_COPY);
    assign is_illegal = (opcode > OP_LAST_ALU);
    assign is_alu     = !is_load && !is_copy && !is_illegal;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.EXEC) state_nxt = T1;
            T1:      state_nxt = is_alu ? T2 : IDLE;
            T2:      state_nxt = T3;
            T3:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // IR only loads on accept, so INSTR changes mid-instruction are invisible.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= IDLE;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.EXEC) ir <= bus.INSTR;
        end
    end

    // Outputs depend only on registered state and IR.
    always_comb begin
        busy      = (state != IDLE);
        done      = 1'b0;
        err       = 1'b0;
        fn        = 4'h0;
        rin       = '0;
        rout      = '0;
        extern_en = 1'b0;
        ain       = 1'b0;
        gin       = 1'b0;
        gout      = 1'b0;
        case (state)
            T1: begin
                if (is_load) begin
                    extern_en = 1'b1;
                    rin       = reg_sel(rx);
                    done      = 1'b1;
                end else if (is_copy) begin
                    rout = reg_sel(ry);
                    rin  = reg_sel(rx);
                    done = 1'b1;
                end else if (is_alu) begin
                    rout = reg_sel(rx);
                    ain  = 1'b1;
                end else begin
                    done = 1'b1;
                    err  = 1'b1;
                end
            end
            T2: begin
                rout = reg_sel(ry);
                fn   = opcode;
                gin  = 1'b1;
            end
            T3: begin
                gout = 1'b1;
                rin  = reg_sel(rx);
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.BUSY   = busy;
    assign bus.DONE   = done;
    assign bus.ERR    = err;
    assign bus.FN     = fn;
    assign bus.RIN    = rin;
    assign bus.ROUT   = rout;
    assign bus.EXTERN = extern_en;
    assign bus.AIN    = ain;
    assign bus.GIN    = gin;
    assign bus.GOUT   = gout;

    a_single_bus_driver: assert property (@(posedge CLK) disable iff (!RSTN)
        $onehot0({|rout, extern_en, gout}));
    a_rin_onehot0: assert property (@(posedge CLK) disable iff (!RSTN)
        $onehot0(rin));
    a_rout_onehot0: assert property (@(posedge CLK) disable iff (!RSTN)
        $onehot0(rout));

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: one task per scenario, hand-computed
// expected control words compared a cycle at a time.
module tb_alu_sequencer;

    logic clk;
    logic rstn;
    int   total;
    int   bad;

    alu_sequencer_if #(.IW(10), .NREG(4)) bus ();

    alu_sequencer #(.IW(10), .NREG(4)) dut (
        .CLK  (clk),
        .RSTN (rstn),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Packed word: {BUSY,DONE,ERR,FN,RIN,ROUT,EXTERN,AIN,GIN,GOUT}
    function automatic logic [18:0] pk(input logic busy, input logic done, input logic err,
                                       input logic [3:0] fn, input logic [3:0] rin,
                                       input logic [3:0] rout, input logic ext,
                                       input logic ain, input logic gin, input logic gout);
        return {busy, done, err, fn, rin, rout, ext, ain, gin, gout};
    endfunction

    function automatic logic [18:0] observed();
        return {bus.BUSY, bus.DONE, bus.ERR, bus.FN, bus.RIN, bus.ROUT,
                bus.EXTERN, bus.AIN, bus.GIN, bus.GOUT};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [18:0] e;
        rstn      = 1'b0;
        bus.EXEC  = 1'b1;
        bus.INSTR = 10'h098;
        #3;
        e = '0; total++;
        if (observed() !== e) begin bad++; $display("FAIL reset_hold got=%05h want=%05h", observed(), e); end
        step();
        e = '0; total++;
        if (observed() !== e) begin bad++; $display("FAIL reset_edge got=%05h want=%05h", observed(), e); end
        bus.EXEC = 1'b0;
        rstn     = 1'b1;
        step();
        e = '0; total++;
        if (observed() !== e) begin bad++; $display("FAIL idle_no_exec got=%05h want=%05h", observed(), e); end
    endtask

    task automatic test_load();
        logic [18:0] e;
        bus.EXEC  = 1'b1;
        bus.INSTR = 10'h030;
        step();
        bus.EXEC  = 1'b0;
        e = pk(1, 1, 0, 4'h0, 4'b1000, 4'b0000, 1, 0, 0, 0); total++;
        if (observed() !== e) begin bad++; $display("FAIL load_t1 got=%05h want=%05h", observed(), e); end
        step();
        e = '0; total++;
        if (observed() !== e) begin bad++; $display("FAIL load_idle got=%05h want=%05h", observed(), e); end
    endtask

    task automatic test_add();
        logic [18:0] e;
        bus.EXEC  = 1'b1;
        bus.INSTR = 10'h098;
        step();
        bus.EXEC  = 1'b0;
        bus.INSTR = 10'h3FF;
        e = pk(1, 0, 0, 4'h0, 4'b0000, 4'b0010, 0, 1, 0, 0); total++;
        if (observed() !== e) begin bad++; $display("FAIL add_t1 got=%05h want=%05h", observed(), e); end
        step();
        e = pk(1, 0, 0, 4'b0010, 4'b0000, 4'b0100, 0, 0, 1, 0); total++;
        if (observed() !== e) begin bad++; $display("FAIL add_t2 got=%05h want=%05h", observed(), e); end
        step();
        e = pk(1, 1, 0, 4'h0, 4'b0010, 4'b0000, 0, 0, 0, 1); total++;
        if (observed() !== e) begin bad++; $display("FAIL add_t3 got=%05h want=%05h", observed(), e); end
        step();
        e = '0; total++;
        if (observed() !== e) begin bad++; $display("FAIL add_idle got=%05h want=%05h", observed(), e); end
    endtask

    task automatic test_copy();
        logic [18:0] e;
        bus.EXEC  = 1'b1;
        bus.INSTR = 10'h04C;
        step();
        bus.EXEC  = 1'b0;
        e = pk(1, 1, 0, 4'h0, 4'b0001, 4'b1000, 0, 0, 0, 0); total++;
        if (observed() !== e) begin bad++; $display("FAIL copy_t1 got=%05h want=%05h", observed(), e); end
        step();
        e = '0; total++;
        if (observed() !== e) begin bad++; $display("FAIL copy_idle got=%05h want=%05h", observed(), e); end
        // COPY R2,R2 with reserved bits set
        bus.EXEC  = 1'b1;
        bus.INSTR = 10'h06A;
        step();
        bus.EXEC  = 1'b0;
        e = pk(1, 1, 0, 4'h0, 4'b0100, 4'b0100, 0, 0, 0, 0); total++;
        if (observed() !== e) begin bad++; $display("FAIL copy_self got=%05h want=%05h", observed(), e); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [18:0] e;
        bus.EXEC  = 1'b1;
        bus.INSTR = 10'h2E4;
        step();
        e = pk(1, 0, 0, 4'h0, 4'b0000, 4'b0100, 0, 1, 0, 0); total++;
        if (observed() !== e) begin bad++; $display("FAIL asr_t1 got=%05h want=%05h", observed(), e); end
        step();
        e = pk(1, 0, 0, 4'hB, 4'b0000, 4'b0010, 0, 0, 1, 0); total++;
        if (observed() !== e) begin bad++; $display("FAIL asr_t2 got=%05h want=%05h", observed(), e); end
        step();
        e = pk(1, 1, 0, 4'h0, 4'b0100, 4'b0000, 0, 0, 0, 1); total++;
        if (observed() !== e) begin bad++; $display("FAIL asr_t3 got=%05h want=%05h", observed(), e); end
        step();
        e = '0; total++;
        if (observed() !== e) begin bad++; $display("FAIL asr_gap got=%05h want=%05h", observed(), e); end
        step();
        e = pk(1, 0, 0, 4'h0, 4'b0000, 4'b0100, 0, 1, 0, 0); total++;
        if (observed() !== e) begin bad++; $display("FAIL asr2_t1 got=%05h want=%05h", observed(), e); end
        step();
        bus.EXEC = 1'b0;
        e = pk(1, 0, 0, 4'hB, 4'b0000, 4'b0010, 0, 0, 1, 0); total++;
        if (observed() !== e) begin bad++; $display("FAIL asr2_t2 got=%05h want=%05h", observed(), e); end
        step();
        step();
        e = '0; total++;
        if (observed() !== e) begin bad++; $display("FAIL asr2_idle got=%05h want=%05h", observed(), e); end
    endtask

    task automatic test_illegal();
        logic [18:0] e;
        bus.EXEC  = 1'b1;
        bus.INSTR = 10'h3C0;
        step();
        bus.EXEC  = 1'b0;
        e = pk(1, 1, 1, 4'h0, 4'b0000, 4'b0000, 0, 0, 0, 0); total++;
        if (observed() !== e) begin bad++; $display("FAIL illegal_t1 got=%05h want=%05h", observed(), e); end
        step();
        e = '0; total++;
        if (observed() !== e) begin bad++; $display("FAIL illegal_idle got=%05h want=%05h", observed(), e); end
    endtask

    task automatic test_reset_mid();
        logic [18:0] e;
        bus.EXEC  = 1'b1;
        bus.INSTR = 10'h098;
        step();
        bus.EXEC  = 1'b0;
        step();
        e = pk(1, 0, 0, 4'b0010, 4'b0000, 4'b0100, 0, 0, 1, 0); total++;
        if (observed() !== e) begin bad++; $display("FAIL mid_t2 got=%05h want=%05h", observed(), e); end
        #2;
        rstn = 1'b0;
        #1;
        e = '0; total++;
        if (observed() !== e) begin bad++; $display("FAIL mid_async got=%05h want=%05h", observed(), e); end
        #2;
        rstn = 1'b1;
        step();
        e = '0; total++;
        if (observed() !== e) begin bad++; $display("FAIL mid_after got=%05h want=%05h", observed(), e); end
        bus.EXEC  = 1'b1;
        bus.INSTR = 10'h030;
        step();
        bus.EXEC  = 1'b0;
        e = pk(1, 1, 0, 4'h0, 4'b1000, 4'b0000, 1, 0, 0, 0); total++;
        if (observed() !== e) begin bad++; $display("FAIL mid_load got=%05h want=%05h", observed(), e); end
        step();
        e = '0; total++;
        if (observed() !== e) begin bad++; $display("FAIL mid_load_idle got=%05h want=%05h", observed(), e); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rstn      = 1'b0;
        bus.EXEC  = 1'b0;
        bus.INSTR = '0;
        test_reset();
        test_load();
        test_add();
        test_copy();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
